// File: rtl/gemm_sequencer.sv
// gemm_sequencer: turns one host command at a time into the per-cycle
// shift, bank-switch, page-select and writeback strobes for the W/X
// register files and the systolic multiplier. Handles M x K by K x N
// matmuls, serial load/store, a fixed drain period and done/err reporting.
module gemm_sequencer #(
   parameter int ARRAY     = 8,
   parameter int DIM_BITS  = 9,
   parameter int PAGE_BITS = 2,
   parameter int LAT       = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [3:0]           cmd_op,
   input  logic [3:0]           cmd_a,
   input  logic [3:0]           cmd_b,
   input  logic [3:0]           cmd_dst,
   input  logic [3:0]           cmd_cfg,
   input  logic [DIM_BITS-1:0]  cmd_k,
   input  logic [3:0]           cmd_m,
   input  logic [3:0]           cmd_n,
   output logic                 w_shift_en,
   output logic                 x_shift_en,
   output logic                 w_switch,
   output logic                 x_switch,
   output logic [PAGE_BITS-1:0] w_rd_page,
   output logic [PAGE_BITS-1:0] x_rd_page,
   output logic                 wr_w,
   output logic                 wr_x,
   output logic [PAGE_BITS-1:0] wr_page,
   output logic                 wr_acc,
   output logic                 relu,
   input  logic [ARRAY-1:0]     mult_clear_out,
   output logic [ARRAY-1:0]     y_valid,
   output logic                 ser_wr,
   output logic                 ser_rd,
   output logic                 busy,
   output logic                 done,
   output logic                 err
);

   localparam int DRAIN_W = $clog2(LAT + 1);

   typedef enum logic [1:0] {IDLE, STREAM, DRAIN, SERIAL} state_t;

   state_t                state_reg;
   logic [DIM_BITS-1:0]   k_last_reg;
   logic [3:0]            m_reg;
   logic [3:0]            m_last_reg;
   logic [3:0]            n_last_reg;
   logic [PAGE_BITS-1:0]  a_page_reg;
   logic [PAGE_BITS-1:0]  b_page_reg;
   logic [PAGE_BITS-1:0]  dst_page_reg;
   logic                  a_is_w_reg;
   logic                  dst_is_w_reg;
   logic                  acc_reg;
   logic                  relu_reg;
   logic                  transpose_reg;
   logic                  ser_mode_reg;
   logic                  ser_read_reg;
   logic [DIM_BITS-1:0]   c_cnt_reg;
   logic [3:0]            l_cnt_reg;
   logic [3:0]            x_cnt_reg;
   logic [DRAIN_W-1:0]    drain_reg;
   logic                  done_reg;
   logic                  err_reg;
   logic [ARRAY-1:0]      y_valid_reg;

   logic                  active;
   logic                  accept;
   logic                  illegal;
   logic                  c_end;
   logic                  l_end;
   logic                  x_end;
   logic                  in_matmul;
   logic                  stream_act;
   logic                  serial_act;
   logic                  w_sw_raw;
   logic                  x_sw_raw;
   logic                  wr_any;
   logic [ARRAY-1:0]      line_mask;
   logic                  unused_bits;

   // Command field bits that carry no meaning here (reserved cfg bit and
   // page-field bits above PAGE_BITS) are folded away explicitly.
   assign unused_bits = ^{cmd_cfg[1], cmd_a, cmd_b, cmd_dst};

   // Strobes are only ever produced in an enabled, non-reset cycle.
   assign active = enable && !reset;
   assign cmd_ready = (state_reg == IDLE) && active;
   assign accept = cmd_valid && cmd_ready;

   // Commands with empty or oversized shapes, unknown opcodes, or a matmul
   // reading both operands from the same file are rejected with err.
   assign illegal = (cmd_op > 4'd3) || (cmd_k == '0) ||
                    (cmd_m == 4'd0) || (cmd_n == 4'd0) ||
                    (int'(cmd_m) > ARRAY) || (int'(cmd_n) > ARRAY) ||
                    ((cmd_op == 4'd1) && (cmd_a[3] == cmd_b[3]));

   assign c_end = (c_cnt_reg == k_last_reg);
   assign l_end = (l_cnt_reg == m_last_reg);
   assign x_end = (x_cnt_reg == n_last_reg);

   // Only the first m_reg multiplier lines carry live results.
   genvar gi;
   generate
      for (gi = 0; gi < ARRAY; gi++) begin : g_mask
         assign line_mask[gi] = (gi < int'(m_reg));
      end
   endgenerate

   // Single FSM: command latch, nested c/l/x counters, drain timer, pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= IDLE;
         k_last_reg    <= '0;
         m_reg         <= '0;
         m_last_reg    <= '0;
         n_last_reg    <= '0;
         a_page_reg    <= '0;
         b_page_reg    <= '0;
         dst_page_reg  <= '0;
         a_is_w_reg    <= 1'b0;
         dst_is_w_reg  <= 1'b0;
         acc_reg       <= 1'b0;
         relu_reg      <= 1'b0;
         transpose_reg <= 1'b0;
         ser_mode_reg  <= 1'b0;
         ser_read_reg  <= 1'b0;
         c_cnt_reg     <= '0;
         l_cnt_reg     <= '0;
         x_cnt_reg     <= '0;
         drain_reg     <= '0;
         done_reg      <= 1'b0;
         err_reg       <= 1'b0;
         y_valid_reg   <= '0;
      end else if (enable) begin
         done_reg    <= 1'b0;
         err_reg     <= 1'b0;
         y_valid_reg <= mult_clear_out & line_mask;
         case (state_reg)
            IDLE: begin
               if (accept && (cmd_op != 4'd0)) begin
                  if (illegal) begin
                     err_reg <= 1'b1;
                  end else begin
                     k_last_reg    <= cmd_k - 1'b1;
                     m_reg         <= cmd_m;
                     m_last_reg    <= cmd_m - 4'd1;
                     n_last_reg    <= cmd_n - 4'd1;
                     a_page_reg    <= cmd_a[PAGE_BITS-1:0];
                     b_page_reg    <= cmd_b[PAGE_BITS-1:0];
                     dst_page_reg  <= cmd_dst[PAGE_BITS-1:0];
                     a_is_w_reg    <= cmd_a[3];
                     dst_is_w_reg  <= cmd_dst[3];
                     acc_reg       <= cmd_cfg[3] && (cmd_op == 4'd1);
                     relu_reg      <= cmd_cfg[2];
                     transpose_reg <= cmd_cfg[0];
                     ser_mode_reg  <= (cmd_op != 4'd1);
                     ser_read_reg  <= (cmd_op == 4'd3);
                     c_cnt_reg     <= '0;
                     l_cnt_reg     <= '0;
                     x_cnt_reg     <= '0;
                     state_reg     <= (cmd_op == 4'd1) ? STREAM : SERIAL;
                  end
               end
            end
            STREAM: begin
               if (c_end) begin
                  c_cnt_reg <= '0;
                  if (l_end) begin
                     l_cnt_reg <= '0;
                     if (x_end) begin
                        x_cnt_reg <= '0;
                        drain_reg <= DRAIN_W'(LAT - 1);
                        state_reg <= DRAIN;
                     end else begin
                        x_cnt_reg <= x_cnt_reg + 4'd1;
                     end
                  end else begin
                     l_cnt_reg <= l_cnt_reg + 4'd1;
                  end
               end else begin
                  c_cnt_reg <= c_cnt_reg + 1'b1;
               end
            end
            DRAIN: begin
               if (drain_reg == '0) begin
                  done_reg  <= 1'b1;
                  state_reg <= IDLE;
               end else begin
                  drain_reg <= drain_reg - 1'b1;
               end
            end
            SERIAL: begin
               if (c_end) begin
                  c_cnt_reg <= '0;
                  done_reg  <= 1'b1;
                  state_reg <= IDLE;
               end else begin
                  c_cnt_reg <= c_cnt_reg + 1'b1;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   // Per-cycle strobes decoded from the registered state and counters.
   assign in_matmul  = (state_reg == STREAM) || (state_reg == DRAIN);
   assign stream_act = (state_reg == STREAM) && active;
   assign serial_act = (state_reg == SERIAL) && active;
   assign w_sw_raw   = stream_act && c_end;
   assign x_sw_raw   = w_sw_raw && l_end;
   assign wr_any     = in_matmul && active && (y_valid_reg != '0);

   assign w_shift_en = stream_act;
   assign x_shift_en = stream_act;
   assign w_switch   = transpose_reg ? x_sw_raw : w_sw_raw;
   assign x_switch   = transpose_reg ? w_sw_raw : x_sw_raw;
   assign w_rd_page  = a_is_w_reg ? a_page_reg : b_page_reg;
   assign x_rd_page  = a_is_w_reg ? b_page_reg : a_page_reg;
   assign wr_w       = wr_any && dst_is_w_reg;
   assign wr_x       = wr_any && !dst_is_w_reg;
   assign wr_page    = ser_mode_reg ? a_page_reg : dst_page_reg;
   assign wr_acc     = acc_reg;
   assign relu       = relu_reg && in_matmul;
   assign y_valid    = y_valid_reg;
   assign ser_wr     = serial_act && !ser_read_reg;
   assign ser_rd     = serial_act && ser_read_reg;
   assign busy       = (state_reg != IDLE);
   assign done       = done_reg && active;
   assign err        = err_reg && active;

endmodule

// File: tb/tb_gemm_sequencer.sv
// Bench for gemm_sequencer: directed commands with hand-computed totals,
// plus a cycle-indexed behavioural model checked on every falling edge.
module tb_gemm_sequencer;

   localparam int ARRAY     = 8;
   localparam int DIM_BITS  = 9;
   localparam int PAGE_BITS = 2;
   localparam int LAT       = 16;

   logic                 clk = 1'b0;
   logic                 reset = 1'b1;
   logic                 enable = 1'b1;
   logic                 cmd_valid = 1'b0;
   logic                 cmd_ready;
   logic [3:0]           cmd_op = '0, cmd_a = '0, cmd_b = '0, cmd_dst = '0, cmd_cfg = '0;
   logic [DIM_BITS-1:0]  cmd_k = '0;
   logic [3:0]           cmd_m = '0, cmd_n = '0;
   logic                 w_shift_en, x_shift_en, w_switch, x_switch;
   logic [PAGE_BITS-1:0] w_rd_page, x_rd_page, wr_page;
   logic                 wr_w, wr_x, wr_acc, relu;
   logic [ARRAY-1:0]     mult_clear_out = '0;
   logic [ARRAY-1:0]     y_valid;
   logic                 ser_wr, ser_rd, busy, done, err;

   int checks = 0;
   int errors = 0;

   gemm_sequencer #(.ARRAY(ARRAY), .DIM_BITS(DIM_BITS), .PAGE_BITS(PAGE_BITS), .LAT(LAT)) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_dst(cmd_dst), .cmd_cfg(cmd_cfg),
      .cmd_k(cmd_k), .cmd_m(cmd_m), .cmd_n(cmd_n),
      .w_shift_en(w_shift_en), .x_shift_en(x_shift_en),
      .w_switch(w_switch), .x_switch(x_switch),
      .w_rd_page(w_rd_page), .x_rd_page(x_rd_page),
      .wr_w(wr_w), .wr_x(wr_x), .wr_page(wr_page), .wr_acc(wr_acc), .relu(relu),
      .mult_clear_out(mult_clear_out), .y_valid(y_valid),
      .ser_wr(ser_wr), .ser_rd(ser_rd), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: a command is described by its kind and the number
   // of enabled cycles elapsed since acceptance (index 0 = first cycle after).
   int         mk = 0, mi = 0, mK = 0, mM = 0, mN = 0;
   logic       mtr = 0, mrelu = 0, macc = 0, err_pend = 0;
   logic [3:0] ma = 0, mb = 0, mdst = 0;
   logic [7:0] yv = 0;

   always @(negedge clk) begin : cmp
      int   T, total;
      logic act, in_op, e_sh, e_ws, e_xs, e_wr;
      logic [7:0] msk;
      act   = enable && !reset;
      T     = mK * mM * mN;
      total = (mk == 1) ? T + LAT : ((mk >= 2) ? mK : 0);
      in_op = (mk != 0) && (mi < total);
      e_sh  = act && (mk == 1) && (mi < T);
      e_ws  = e_sh && ((mi % mK) == mK - 1);
      e_xs  = e_sh && ((mi % (mK * mM)) == mK * mM - 1);
      e_wr  = act && (mk == 1) && in_op && (yv != 0);
      chk("cmd_ready", int'(cmd_ready), int'(act && !in_op));
      chk("w_shift_en", int'(w_shift_en), int'(e_sh));
      chk("x_shift_en", int'(x_shift_en), int'(e_sh));
      chk("w_switch", int'(w_switch), int'(mtr ? e_xs : e_ws));
      chk("x_switch", int'(x_switch), int'(mtr ? e_ws : e_xs));
      chk("ser_wr", int'(ser_wr), int'(act && (mk == 2) && in_op));
      chk("ser_rd", int'(ser_rd), int'(act && (mk == 3) && in_op));
      chk("done", int'(done), int'(act && (mk != 0) && (mi == total)));
      chk("err", int'(err), int'(act && err_pend));
      chk("wr_w", int'(wr_w), int'(e_wr && mdst[3]));
      chk("wr_x", int'(wr_x), int'(e_wr && !mdst[3]));
      if (!reset) begin
         chk("busy", int'(busy), int'(in_op));
         chk("y_valid", int'(y_valid), int'(yv));
         chk("relu", int'(relu), int'((mk == 1) && in_op && mrelu));
         if (mk == 1 && in_op) begin
            chk("w_rd_page", int'(w_rd_page), int'(ma[3] ? ma[1:0] : mb[1:0]));
            chk("x_rd_page", int'(x_rd_page), int'(ma[3] ? mb[1:0] : ma[1:0]));
            chk("wr_page_mm", int'(wr_page), int'(mdst[1:0]));
            chk("wr_acc", int'(wr_acc), int'(macc));
         end
         if (mk >= 2 && in_op) chk("wr_page_ser", int'(wr_page), int'(ma[1:0]));
      end
      // advance the model across the coming rising edge
      if (reset) begin
         mk = 0; mi = 0; err_pend = 0; yv = '0; mM = 0;
      end else if (enable) begin
         for (int i = 0; i < 8; i++) msk[i] = (i < mM);
         yv = mult_clear_out & msk;
         err_pend = 1'b0;
         if (mk != 0) begin
            if (mi >= total) mk = 0;
            else mi++;
         end
         if (!in_op && cmd_valid && cmd_op != 0) begin
            if (cmd_op > 3 || cmd_k == 0 || cmd_m == 0 || cmd_n == 0 || cmd_m > 8 || cmd_n > 8 ||
                (cmd_op == 1 && cmd_a[3] == cmd_b[3])) begin
               err_pend = 1'b1;
            end else begin
               mk = int'(cmd_op); mi = 0;
               mK = int'(cmd_k); mM = int'(cmd_m); mN = int'(cmd_n);
               ma = cmd_a; mb = cmd_b; mdst = cmd_dst;
               mtr = cmd_cfg[0]; mrelu = cmd_cfg[2]; macc = cmd_cfg[3];
            end
         end
      end
   end

   // Random clear_out pattern from the multiplier every cycle.
   initial begin
      forever begin
         @(posedge clk);
         #1 mult_clear_out = 8'($urandom);
      end
   end

   task automatic issue(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] dst, input logic [3:0] cfg, input int k,
                        input int m, input int n);
      @(posedge clk);
      #1;
      enable = 1'b1; reset = 1'b0;
      cmd_op = op; cmd_a = a; cmd_b = b; cmd_dst = dst; cmd_cfg = cfg;
      cmd_k = DIM_BITS'(k); cmd_m = 4'(m); cmd_n = 4'(n);
      cmd_valid = 1'b1;
      @(negedge clk);
      chk("ready_at_issue", int'(cmd_ready), 1);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   // Runs up to budget cycles after acceptance, tallying strobes; stops on done.
   task automatic run_count(input int budget, input int en_off, input int rst_at,
                            output int sh, output int ws, output int xs, output int sw,
                            output int sr, output int done_at, output int err_at,
                            output int str_off, output int busy_after,
                            output int wrp1, output int wrd1, output int xrd1);
      sh = 0; ws = 0; xs = 0; sw = 0; sr = 0; done_at = 0; err_at = 0;
      str_off = 0; busy_after = -1; wrp1 = -1; wrd1 = -1; xrd1 = -1;
      for (int cyc = 1; cyc <= budget; cyc++) begin
         if (cyc > 1) begin
            @(posedge clk);
            #1;
         end
         enable = !(en_off > 0 && cyc >= en_off && cyc < en_off + 10);
         reset  = (rst_at > 0 && cyc == rst_at);
         @(negedge clk);
         sh += int'(w_shift_en); ws += int'(w_switch); xs += int'(x_switch);
         sw += int'(ser_wr); sr += int'(ser_rd);
         if (!enable) str_off += int'(w_shift_en | x_shift_en | w_switch | x_switch |
                                     ser_wr | ser_rd | wr_w | wr_x);
         if (rst_at > 0 && cyc == rst_at + 1) busy_after = int'(busy);
         if (cyc == 1) begin
            wrp1 = int'(wr_page); wrd1 = int'(w_rd_page); xrd1 = int'(x_rd_page);
         end
         if (err && err_at == 0) err_at = cyc;
         if (done) begin
            done_at = cyc;
            chk("ready_with_done", int'(cmd_ready), 1);
            break;
         end
      end
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
      $fatal(1, "timeout");
   end

   initial begin
      int sh, ws, xs, sw, sr, da, ea, so, ba, p1, r1, q1;
      repeat (3) begin
         @(negedge clk);
         chk("ready_in_reset", int'(cmd_ready), 0);
      end
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("ready_after_reset", int'(cmd_ready), 1);
      chk("busy_after_reset", int'(busy), 0);

      // 8x8x8 matmul: W0 x X1 -> X2 with relu
      issue(4'd1, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 8, 8, 8);
      run_count(700, 0, 0, sh, ws, xs, sw, sr, da, ea, so, ba, p1, r1, q1);
      $display("mm 8x8x8: shifts=%0d w_sw=%0d x_sw=%0d done_at=%0d", sh, ws, xs, da);
      chk("mm888_shifts", sh, 512); chk("mm888_wsw", ws, 64);
      chk("mm888_xsw", xs, 8); chk("mm888_done", da, 529);
      chk("mm888_wrd", r1, 0); chk("mm888_xrd", q1, 1); chk("mm888_wrp", p1, 2);

      // 3x5 by K=7 transposed: X0 x W3 -> W1 accumulate
      issue(4'd1, 4'b0000, 4'b1011, 4'b1001, 4'b1001, 7, 3, 5);
      run_count(300, 0, 0, sh, ws, xs, sw, sr, da, ea, so, ba, p1, r1, q1);
      $display("mm 3x5 k7 tr: shifts=%0d w_sw=%0d x_sw=%0d done_at=%0d", sh, ws, xs, da);
      chk("mm357_shifts", sh, 105); chk("mm357_xsw", xs, 15);
      chk("mm357_wsw", ws, 5); chk("mm357_done", da, 122);
      chk("mm357_wrd", r1, 3); chk("mm357_xrd", q1, 0);

      // illegal: M=0, both operands in X, unknown opcode
      issue(4'd1, 4'b1000, 4'b0001, 4'b0010, 4'b0000, 4, 0, 2);
      run_count(4, 0, 0, sh, ws, xs, sw, sr, da, ea, so, ba, p1, r1, q1);
      $display("illegal m=0: err_at=%0d shifts=%0d done_at=%0d", ea, sh, da);
      chk("ill_m0_err", ea, 1); chk("ill_m0_shifts", sh, 0); chk("ill_m0_done", da, 0);
      issue(4'd1, 4'b0001, 4'b0010, 4'b0011, 4'b0000, 4, 2, 2);
      run_count(4, 0, 0, sh, ws, xs, sw, sr, da, ea, so, ba, p1, r1, q1);
      $display("illegal a,b in X: err_at=%0d shifts=%0d", ea, sh);
      chk("ill_xx_err", ea, 1); chk("ill_xx_shifts", sh, 0);
      issue(4'd5, 4'b1000, 4'b0001, 4'b0010, 4'b0000, 4, 2, 2);
      run_count(4, 0, 0, sh, ws, xs, sw, sr, da, ea, so, ba, p1, r1, q1);
      $display("illegal op5: err_at=%0d", ea);
      chk("ill_op5_err", ea, 1);

      // nop: accepted silently
      issue(4'd0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
      run_count(4, 0, 0, sh, ws, xs, sw, sr, da, ea, so, ba, p1, r1, q1);
      $display("nop: err_at=%0d done_at=%0d", ea, da);
      chk("nop_err", ea, 0); chk("nop_done", da, 0);

      // serial load then store, K=20, page W2
      issue(4'd2, 4'b1010, 4'b0000, 4'b0000, 4'b0000, 20, 1, 1);
      run_count(40, 0, 0, sh, ws, xs, sw, sr, da, ea, so, ba, p1, r1, q1);
      $display("serial load: ser_wr=%0d page=%0d done_at=%0d", sw, p1, da);
      chk("ld_count", sw, 20); chk("ld_rd", sr, 0); chk("ld_page", p1, 2); chk("ld_done", da, 21);
      issue(4'd3, 4'b1010, 4'b0000, 4'b0000, 4'b0000, 20, 1, 1);
      run_count(40, 0, 0, sh, ws, xs, sw, sr, da, ea, so, ba, p1, r1, q1);
      $display("serial store: ser_rd=%0d page=%0d done_at=%0d", sr, p1, da);
      chk("st_count", sr, 20); chk("st_wr", sw, 0); chk("st_page", p1, 2); chk("st_done", da, 21);

      // enable low for 10 cycles mid-STREAM (K=4,M=2,N=2)
      issue(4'd1, 4'b1001, 4'b0011, 4'b1000, 4'b0000, 4, 2, 2);
      run_count(80, 5, 0, sh, ws, xs, sw, sr, da, ea, so, ba, p1, r1, q1);
      $display("enable gap: shifts=%0d done_at=%0d strobes_while_off=%0d", sh, da, so);
      chk("gap_shifts", sh, 16); chk("gap_done", da, 43); chk("gap_off_strobes", so, 0);

      // reset during DRAIN (K=2,M=1,N=1 drains in cycles 3..18)
      issue(4'd1, 4'b1000, 4'b0000, 4'b0001, 4'b0000, 2, 1, 1);
      run_count(30, 0, 6, sh, ws, xs, sw, sr, da, ea, so, ba, p1, r1, q1);
      $display("reset in drain: shifts=%0d done_at=%0d busy_after=%0d", sh, da, ba);
      chk("rst_shifts", sh, 2); chk("rst_done", da, 0); chk("rst_busy", ba, 0);
      issue(4'd2, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 3, 1, 1);
      run_count(10, 0, 0, sh, ws, xs, sw, sr, da, ea, so, ba, p1, r1, q1);
      $display("after reset load: ser_wr=%0d done_at=%0d", sw, da);
      chk("post_rst_count", sw, 3); chk("post_rst_done", da, 4);

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
